ps2_host_ctrl: RTL
==================

Name: ps2_host_ctrl

Overview:
Host-to-device command sequencer for the PS/2 port. It transmits a command byte and an optional argument byte to the keyboard, such as ED+LED mask, F3+typematic, F4, or FF. It does this by driving the open-drain clock/data lines through output-enables, then checks the device response bytes delivered by the existing PS/2 receiver. It sits beside the receiver on the shared ps2_clk/ps2_data pins and gates the receiver's byte stream to the key decoder while a command is in flight.

Parameters:
INHIBIT_CYC, 5000, clk_i cycles ps2_clk is held low before request-to-send (≥100 µs at 50 MHz)
TIMEOUT_CYC, 750000, max clk_i cycles spent in any state that waits on the device (15 ms at 50 MHz)
RETRY_MAX, 2, number of resends allowed after an FE response, per byte

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-low
cmd_valid_i  in  1  command request; sampled only when cmd_ready_o=1
cmd_byte_i  in  8  command byte
cmd_arg_i  in  8  argument byte
cmd_has_arg_i  in  1  1 = send cmd_arg_i after the command is acknowledged
cmd_ready_o  out  1  block idle, accepts a command
ps2_clk_i  in  1  raw PS/2 clock pin (async)
ps2_data_i  in  1  raw PS/2 data pin (async)
ps2_clk_oe_o  out  1  1 = pull ps2_clk low
ps2_data_oe_o  out  1  1 = pull ps2_data low
rx_data_i  in  8  byte from receiver
rx_done_i  in  1  one-cycle strobe, rx_data_i valid
rx_gate_o  out  1  1 = receiver bytes belong to this block; decoder must ignore them
done_o  out  1  one-cycle pulse, command completed OK
err_o  out  1  one-cycle pulse, command failed
err_code_o  out  3  error cause; valid with err_o, held until next command

Behaviour:
- Reset (rst_i=0 at clk_i edge): state IDLE. cmd_ready_o=1. All of ps2_clk_oe_o, ps2_data_oe_o, rx_gate_o, done_o, err_o = 0. err_code_o=0. Counters cleared. Reset mid-transfer releases both lines on the next cycle.
- ps2_clk_i and ps2_data_i pass through 2-FF synchronisers. A falling edge is detected as d1=0 & d2=1.
- Accept: in IDLE with cmd_valid_i=1, latch cmd/arg/has_arg. cmd_ready_o drops the next cycle and rx_gate_o=1 from then until return to IDLE. The current byte is cmd_byte_i. Per-byte retry count = 0.
- Shift register: frame = {stop=1, parity, d7..d0}. Parity is odd, i.e. ~^byte.
- States:
  - INHIBIT: clk_oe=1 for INHIBIT_CYC cycles, then → RTS.
  - RTS: data_oe=1 (start bit), clk_oe=0. → TX_BITS, bit index = 0.
  - TX_BITS: on each ps2 falling edge, set data_oe = ~frame[idx] and idx++. Edges 1-8 present d0..d7, edge 9 presents parity, edge 10 releases data (stop). After edge 10 → TX_ACK.
  - TX_ACK: on the next falling edge, sample data. If 0 → TX_IDLE; if 1 → error code 2.
  - TX_IDLE: wait for synced clk=1 and data=1 → WAIT_RSP.
  - WAIT_RSP: on rx_done_i:
    - FA: if the current byte is the command and has_arg=1, load the arg, reset the retry count → INHIBIT. Otherwise → DONE.
    - FE: if retry < RETRY_MAX, retry++ → INHIBIT (same byte). Otherwise error code 3.
    - Any other byte: error code 4.
  - DONE: done_o=1 for one cycle → IDLE.
  - ERR: err_o=1 for one cycle, err_code_o latched, both oe=0 → IDLE.
- Timeout: a single counter clears on every state entry and on every ps2 falling edge. It increments in TX_BITS, TX_ACK, TX_IDLE and WAIT_RSP. At TIMEOUT_CYC-1 → ERR code 1. INHIBIT and RTS are not timed by this counter.
- Error codes: 1 timeout, 2 no line ack, 3 resend exhausted, 4 unexpected response, 5 BAT fail (optional feature only).
- rx_done_i outside WAIT_RSP (and outside WAIT_BAT) is ignored by this block.
- cmd_valid_i while busy is ignored; no queueing.
- Never drive clk_oe and data_oe such that the clock is held low while the data line is in TX_BITS.
- Latency: done_o asserts 1 cycle after the FA strobe.

Optional Feature:
PS2_HOST_BAT_EN
- Defined: when the command byte is FF and its FA arrives, go to WAIT_BAT instead of DONE. WAIT_BAT has its own timeout of 50×TIMEOUT_CYC. AA → DONE; FC → ERR code 5; other → ERR code 4; timeout → ERR code 1.
- Undefined: FF completes on FA like any other command, and WAIT_BAT plus its counter are absent.

Test Plan:
1. Send F4, no arg, with a device model that acks then returns FA → frame bits 0,0,1,0,1,1,1,1 then parity 0. done_o pulses once, err_o=0, rx_gate_o low after completion.
2. Send ED with arg 07 → two frames (ED, then 07, parity 0), with FA after each. Exactly one done_o, and the decoder-side gate covers both FA bytes.
3. Model answers FE three times to F3 with RETRY_MAX=2 → three transmissions of F3, then err_o with err_code_o=3.
4. Model stops clocking after edge 4 → err_o code 1 at TIMEOUT_CYC cycles after the last edge, both oe outputs 0.
5. Model leaves data high at the ack edge → err code 2. A separate case with response 55 → err code 4.
6. Reset pulsed low mid TX_BITS → both oe=0, cmd_ready_o=1 on the next cycle. Then a new F4 completes normally.

Source files
------------

// File: rtl/ps2_host_ctrl_if.sv
// rtl/ps2_host_ctrl_if.sv - command, pin and receiver-side signal bundle for ps2_host_ctrl
//
// Purpose: groups every ps2_host_ctrl signal except clk_i/rst_i.
//    slave  : the controller itself
//    master : the surrounding system (command source, pin pads, PS/2 receiver)
// Signals:
//    cmd_valid_i/cmd_byte_i/cmd_arg_i/cmd_has_arg_i/cmd_ready_o : command request
//    ps2_clk_i/ps2_data_i        : raw pin levels (asynchronous)
//    ps2_clk_oe_o/ps2_data_oe_o  : 1 pulls the open-drain line low
//    rx_data_i/rx_done_i         : bytes from the existing receiver
//    rx_gate_o                   : receiver bytes belong to the controller
//    done_o/err_o/err_code_o     : completion status
interface ps2_host_ctrl_if;
   logic       cmd_valid_i;
   logic [7:0] cmd_byte_i;
   logic [7:0] cmd_arg_i;
   logic       cmd_has_arg_i;
   logic       cmd_ready_o;
   logic       ps2_clk_i;
   logic       ps2_data_i;
   logic       ps2_clk_oe_o;
   logic       ps2_data_oe_o;
   logic [7:0] rx_data_i;
   logic       rx_done_i;
   logic       rx_gate_o;
   logic       done_o;
   logic       err_o;
   logic [2:0] err_code_o;

   modport master (
      output cmd_valid_i, cmd_byte_i, cmd_arg_i, cmd_has_arg_i,
             ps2_clk_i, ps2_data_i, rx_data_i, rx_done_i,
      input  cmd_ready_o, ps2_clk_oe_o, ps2_data_oe_o, rx_gate_o,
             done_o, err_o, err_code_o
   );

   modport slave (
      input  cmd_valid_i, cmd_byte_i, cmd_arg_i, cmd_has_arg_i,
             ps2_clk_i, ps2_data_i, rx_data_i, rx_done_i,
      output cmd_ready_o, ps2_clk_oe_o, ps2_data_oe_o, rx_gate_o,
             done_o, err_o, err_code_o
   );
endinterface

// File: rtl/ps2_host_ctrl.sv
// rtl/ps2_host_ctrl.sv - PS/2 host-to-device command sequencer
//
// Purpose: sends a command byte (and optionally an argument byte) to a PS/2
// device by driving the open-drain clock/data lines, then checks the device
// response bytes coming from the existing receiver.
// Ports:
//    clk_i : system clock
//    rst_i : synchronous active-low reset
//    bus   : ps2_host_ctrl_if.slave (command handshake, pins, receiver, status)
// Parameters:
//    INHIBIT_CYC : cycles ps2_clk is held low before request-to-send
//    TIMEOUT_CYC : max cycles in any state waiting on the device
//    RETRY_MAX   : resends allowed after FE, per byte
// Optional feature macro: PS2_HOST_BAT_EN
//    defined   : FF acknowledged by FA then waits for BAT result (AA ok, FC fail)
//    undefined : FF completes on FA like any other command
module ps2_host_ctrl #(
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 750000,
   parameter int RETRY_MAX   = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   ps2_host_ctrl_if.slave bus
);

   localparam int CMAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int RW   = $clog2(RETRY_MAX + 2);
`ifdef PS2_HOST_BAT_EN
   localparam int BW   = $clog2(50 * TIMEOUT_CYC + 1);
`endif

`ifdef PS2_HOST_BAT_EN
   typedef enum logic [3:0] {
      IDLE, INHIBIT, RTS, TX_BITS, TX_ACK, TX_IDLE, WAIT_RSP, DONE, ERR, WAIT_BAT
   } state_t;
`else
   typedef enum logic [3:0] {
      IDLE, INHIBIT, RTS, TX_BITS, TX_ACK, TX_IDLE, WAIT_RSP, DONE, ERR
   } state_t;
`endif

   state_t        state, state_nxt;

   logic [1:0]    clk_sync, data_sync;
   logic          clk_d2;
   logic          clk_s, data_s, fall;

   logic [CW-1:0] tmr;
   logic [3:0]    idx;
   logic          data_r;
   logic [7:0]    cur_byte, arg_byte;
   logic          has_arg, arg_phase;
   logic [RW-1:0] retry;
   logic [2:0]    err_code;
   logic [9:0]    frame;
`ifdef PS2_HOST_BAT_EN
   logic [BW-1:0] bat_tmr;
`endif

   logic          timed, load_cmd, load_arg, retry_inc, err_set;
   logic [2:0]    err_nxt;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];
   assign fall   = ~clk_s & clk_d2;
   // Stop bit, odd parity, then d7..d0; index 0 goes out first.
   assign frame  = {1'b1, ~^cur_byte, cur_byte};

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_cmd  = 1'b0;
      load_arg  = 1'b0;
      retry_inc = 1'b0;
      err_set   = 1'b0;
      err_nxt   = 3'd0;
      timed     = (state == TX_BITS) || (state == TX_ACK) ||
                  (state == TX_IDLE) || (state == WAIT_RSP);
      case (state)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               load_cmd  = 1'b1;
               state_nxt = INHIBIT;
            end
         end
         INHIBIT: begin
            if (tmr == CW'(INHIBIT_CYC - 1)) state_nxt = RTS;
         end
         RTS: state_nxt = TX_BITS;
         TX_BITS: begin
            // idx 9 is the stop bit; once it is presented the line is released.
            if (fall && idx == 4'd9) state_nxt = TX_ACK;
         end
         TX_ACK: begin
            if (fall) begin
               if (!data_s) begin
                  state_nxt = TX_IDLE;
               end else begin
                  state_nxt = ERR;
                  err_set   = 1'b1;
                  err_nxt   = 3'd2;
               end
            end
         end
         TX_IDLE: begin
            if (clk_s && data_s) state_nxt = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (bus.rx_done_i) begin
               if (bus.rx_data_i == 8'hFA) begin
                  if (!arg_phase && has_arg) begin
                     load_arg  = 1'b1;
                     state_nxt = INHIBIT;
                  end
`ifdef PS2_HOST_BAT_EN
                  else if (!arg_phase && cur_byte == 8'hFF) state_nxt = WAIT_BAT;
                  else state_nxt = DONE;
`else
                  else state_nxt = DONE;
`endif
               end else if (bus.rx_data_i == 8'hFE) begin
                  if (retry < RW'(RETRY_MAX)) begin
                     retry_inc = 1'b1;
                     state_nxt = INHIBIT;
                  end else begin
                     state_nxt = ERR;
                     err_set   = 1'b1;
                     err_nxt   = 3'd3;
                  end
               end else begin
                  state_nxt = ERR;
                  err_set   = 1'b1;
                  err_nxt   = 3'd4;
               end
            end
         end
`ifdef PS2_HOST_BAT_EN
         WAIT_BAT: begin
            if (bus.rx_done_i) begin
               state_nxt = (bus.rx_data_i == 8'hAA) ? DONE : ERR;
               err_set   = (bus.rx_data_i != 8'hAA);
               err_nxt   = (bus.rx_data_i == 8'hFC) ? 3'd5 : 3'd4;
            end else if (bat_tmr == BW'(50 * TIMEOUT_CYC - 1)) begin
               state_nxt = ERR;
               err_set   = 1'b1;
               err_nxt   = 3'd1;
            end
         end
`endif
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // A real transition or a ps2 edge in the same cycle counts as progress.
      if (timed && !fall && state_nxt == state && tmr == CW'(TIMEOUT_CYC - 1)) begin
         state_nxt = ERR;
         err_set   = 1'b1;
         err_nxt   = 3'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_d2    <= 1'b1;
         tmr       <= '0;
         idx       <= 4'd0;
         data_r    <= 1'b0;
         cur_byte  <= 8'h00;
         arg_byte  <= 8'h00;
         has_arg   <= 1'b0;
         arg_phase <= 1'b0;
         retry     <= '0;
         err_code  <= 3'd0;
`ifdef PS2_HOST_BAT_EN
         bat_tmr   <= '0;
`endif
      end else begin
         clk_sync  <= {clk_sync[0], bus.ps2_clk_i};
         data_sync <= {data_sync[0], bus.ps2_data_i};
         clk_d2    <= clk_sync[1];

         // Shared counter: measures the inhibit hold, and times every wait on the device.
         if (state_nxt != state) begin
            tmr <= '0;
         end else if (timed && fall) begin
            tmr <= '0;
         end else if (timed || state == INHIBIT) begin
            tmr <= tmr + 1'b1;
         end

`ifdef PS2_HOST_BAT_EN
         if (state_nxt != state) begin
            bat_tmr <= '0;
         end else if (state == WAIT_BAT) begin
            bat_tmr <= bat_tmr + 1'b1;
         end
`endif

         if (load_cmd) begin
            cur_byte  <= bus.cmd_byte_i;
            arg_byte  <= bus.cmd_arg_i;
            has_arg   <= bus.cmd_has_arg_i;
            arg_phase <= 1'b0;
            retry     <= '0;
            err_code  <= 3'd0;
         end
         if (load_arg) begin
            cur_byte  <= arg_byte;
            arg_phase <= 1'b1;
            retry     <= '0;
         end
         if (retry_inc) retry <= retry + 1'b1;
         if (err_set)   err_code <= err_nxt;

         // data_r holds the start bit from RTS until the first device edge.
         if (state == RTS) begin
            idx    <= 4'd0;
            data_r <= 1'b1;
         end else if (state == TX_BITS && fall) begin
            data_r <= ~frame[idx];
            idx    <= idx + 4'd1;
         end
      end
   end

   assign bus.cmd_ready_o   = (state == IDLE);
   assign bus.rx_gate_o     = (state != IDLE);
   assign bus.done_o        = (state == DONE);
   assign bus.err_o         = (state == ERR);
   assign bus.err_code_o    = err_code;
   assign bus.ps2_clk_oe_o  = (state == INHIBIT);
   assign bus.ps2_data_oe_o = (state == RTS) || ((state == TX_BITS) && data_r);

endmodule
